// File: rtl/svo_term_enc_pkg.sv
// Shared definitions for the SVO terminal encoder: default video timing,
// palette defaults, FSM state codes and timing-derivation helpers.
package svo_term_enc_pkg;

  // Default 640x480@60 timing (pixels / lines).
  localparam int unsigned SVO_HOR_PIXELS_DEF      = 640;
  localparam int unsigned SVO_HOR_FRONT_PORCH_DEF = 16;
  localparam int unsigned SVO_HOR_SYNC_DEF        = 96;
  localparam int unsigned SVO_HOR_BACK_PORCH_DEF  = 48;
  localparam int unsigned SVO_VER_PIXELS_DEF      = 480;
  localparam int unsigned SVO_VER_FRONT_PORCH_DEF = 10;
  localparam int unsigned SVO_VER_SYNC_DEF        = 2;
  localparam int unsigned SVO_VER_BACK_PORCH_DEF  = 33;

  // Sync polarity and the 2-bit palette.
  localparam logic        SYNC_ACTIVE_DEF = 1'b0;
  localparam logic [23:0] COLOR0_DEF      = 24'h000000;
  localparam logic [23:0] COLOR1_DEF      = 24'h555555;
  localparam logic [23:0] COLOR2_DEF      = 24'hAAAAAA;
  localparam logic [23:0] COLOR3_DEF      = 24'hFFFFFF;

  // Encoder FSM state codes.
  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One output pixel, red in the top byte.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned seg_total(input int unsigned pix, input int unsigned fp,
                                            input int unsigned sw, input int unsigned bp);
    return pix + fp + sw + bp;
  endfunction

  // Counter width able to hold max(h_tot, v_tot) - 1.
  function automatic int unsigned cnt_width(input int unsigned h_tot, input int unsigned v_tot);
    int unsigned m;
    m = (h_tot > v_tot) ? h_tot : v_tot;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/svo_term_timing.sv
// Free-running raster counters and the timing flags derived from them.
// Origin (0,0) is the first active pixel; blanking follows the active area.
module svo_term_timing
  import svo_term_enc_pkg::*;
#(
  parameter int unsigned SVO_HOR_PIXELS      = SVO_HOR_PIXELS_DEF,
  parameter int unsigned SVO_HOR_FRONT_PORCH = SVO_HOR_FRONT_PORCH_DEF,
  parameter int unsigned SVO_HOR_SYNC        = SVO_HOR_SYNC_DEF,
  parameter int unsigned SVO_HOR_BACK_PORCH  = SVO_HOR_BACK_PORCH_DEF,
  parameter int unsigned SVO_VER_PIXELS      = SVO_VER_PIXELS_DEF,
  parameter int unsigned SVO_VER_FRONT_PORCH = SVO_VER_FRONT_PORCH_DEF,
  parameter int unsigned SVO_VER_SYNC        = SVO_VER_SYNC_DEF,
  parameter int unsigned SVO_VER_BACK_PORCH  = SVO_VER_BACK_PORCH_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic active_c,
  output logic hsync_c,
  output logic vsync_c,
  output logic at_origin_c
);

  localparam int unsigned H_TOTAL = seg_total(SVO_HOR_PIXELS, SVO_HOR_FRONT_PORCH,
                                              SVO_HOR_SYNC, SVO_HOR_BACK_PORCH);
  localparam int unsigned V_TOTAL = seg_total(SVO_VER_PIXELS, SVO_VER_FRONT_PORCH,
                                              SVO_VER_SYNC, SVO_VER_BACK_PORCH);
  localparam int unsigned CNT_W   = cnt_width(H_TOTAL, V_TOTAL);

  // Inclusive bounds keep every constant at or below TOTAL-1, so none overflow CNT_W.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(SVO_HOR_PIXELS - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(SVO_VER_PIXELS - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(SVO_HOR_PIXELS + SVO_HOR_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(SVO_HOR_PIXELS + SVO_HOR_FRONT_PORCH
                                                   + SVO_HOR_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(SVO_VER_PIXELS + SVO_VER_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(SVO_VER_PIXELS + SVO_VER_FRONT_PORCH
                                                   + SVO_VER_SYNC - 1);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;

  // Raster position: held at origin until the synchronized reset release, then free-running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (run) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  assign active_c    = (hcnt <= H_ACT_LAST) && (vcnt <= V_ACT_LAST);
  assign hsync_c     = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
  assign vsync_c     = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
  assign at_origin_c = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/svo_term_enc.sv
// SVO terminal encoder: turns an AXI-stream of 2-bit pixel codes into
// registered RGB + sync/de video, locking to the stream's frame start.
module svo_term_enc
  import svo_term_enc_pkg::*;
#(
  parameter int unsigned SVO_HOR_PIXELS      = SVO_HOR_PIXELS_DEF,
  parameter int unsigned SVO_HOR_FRONT_PORCH = SVO_HOR_FRONT_PORCH_DEF,
  parameter int unsigned SVO_HOR_SYNC        = SVO_HOR_SYNC_DEF,
  parameter int unsigned SVO_HOR_BACK_PORCH  = SVO_HOR_BACK_PORCH_DEF,
  parameter int unsigned SVO_VER_PIXELS      = SVO_VER_PIXELS_DEF,
  parameter int unsigned SVO_VER_FRONT_PORCH = SVO_VER_FRONT_PORCH_DEF,
  parameter int unsigned SVO_VER_SYNC        = SVO_VER_SYNC_DEF,
  parameter int unsigned SVO_VER_BACK_PORCH  = SVO_VER_BACK_PORCH_DEF,
  parameter logic        SYNC_ACTIVE         = SYNC_ACTIVE_DEF,
  parameter logic [23:0] COLOR0              = COLOR0_DEF,
  parameter logic [23:0] COLOR1              = COLOR1_DEF,
  parameter logic [23:0] COLOR2              = COLOR2_DEF,
  parameter logic [23:0] COLOR3              = COLOR3_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_axis_tvalid,
  output logic        in_axis_tready,
  input  logic [1:0]  in_axis_tdata,
  input  logic        in_axis_tuser,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        locked,
  output logic        underflow,
  output logic        frame_err
);

  logic [1:0] rst_sync;
  logic       run;
  logic       active;
  logic       hs_on;
  logic       vs_on;
  logic       at_origin;
  logic [0:0] state;
  logic [0:0] state_next;
  logic       ready;
  logic       take_pixel;
  logic       uf_next;
  logic       fe_next;
  rgb_t       pix_color;

  // Reset assert is immediate; release passes two flops before the raster starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  svo_term_timing #(
    .SVO_HOR_PIXELS      (SVO_HOR_PIXELS),
    .SVO_HOR_FRONT_PORCH (SVO_HOR_FRONT_PORCH),
    .SVO_HOR_SYNC        (SVO_HOR_SYNC),
    .SVO_HOR_BACK_PORCH  (SVO_HOR_BACK_PORCH),
    .SVO_VER_PIXELS      (SVO_VER_PIXELS),
    .SVO_VER_FRONT_PORCH (SVO_VER_FRONT_PORCH),
    .SVO_VER_SYNC        (SVO_VER_SYNC),
    .SVO_VER_BACK_PORCH  (SVO_VER_BACK_PORCH)
  ) u_timing (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .active_c    (active),
    .hsync_c     (hs_on),
    .vsync_c     (vs_on),
    .at_origin_c (at_origin)
  );

  // Lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Beat acceptance, pixel take and error detection for the current raster position.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    take_pixel = 1'b0;
    uf_next    = 1'b0;
    fe_next    = 1'b0;
    if (run) begin
      case (state)
        ST_SYNC: begin
          // Mid-frame beats are flushed; the frame-start beat waits for the origin.
          if (in_axis_tvalid) begin
            if (!in_axis_tuser) begin
              ready = 1'b1;
            end else if (at_origin) begin
              ready      = 1'b1;
              take_pixel = 1'b1;
              state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (active) begin
            if (!in_axis_tvalid) begin
              ready      = 1'b1;
              uf_next    = 1'b1;
              state_next = ST_SYNC;
            end else if (in_axis_tuser != at_origin) begin
              // Frame marker out of place: leave the beat for the next origin.
              fe_next    = 1'b1;
              state_next = ST_SYNC;
            end else begin
              ready      = 1'b1;
              take_pixel = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_SYNC;
        end
      endcase
      // A framing error outranks an underflow reported on the same clock.
      if (fe_next) begin
        uf_next = 1'b0;
      end
    end
  end

  assign in_axis_tready = ready;

  // Palette lookup of the incoming pixel code.
  always_comb begin
    pix_color = COLOR0;
    case (in_axis_tdata)
      2'd0:    pix_color = COLOR0;
      2'd1:    pix_color = COLOR1;
      2'd2:    pix_color = COLOR2;
      default: pix_color = COLOR3;
    endcase
  end

  // Registered video outputs, all aligned to the raster position just processed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb       <= 24'h000000;
      de        <= 1'b0;
      hsync     <= ~SYNC_ACTIVE;
      vsync     <= ~SYNC_ACTIVE;
      locked    <= 1'b0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rgb       <= take_pixel ? pix_color : COLOR0;
      de        <= run && active;
      hsync     <= (run && hs_on) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync     <= (run && vs_on) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      locked    <= (state_next == ST_RUN);
      underflow <= uf_next;
      frame_err <= fe_next;
    end
  end

endmodule

// File: tb/tb_svo_term_enc.sv
// Self-checking bench for svo_term_enc on a reduced 8x4 raster.
module tb_svo_term_enc;

  localparam int HP   = 8;
  localparam int HFP  = 2;
  localparam int HSW  = 3;
  localparam int HBP  = 2;
  localparam int VP   = 4;
  localparam int VFP  = 1;
  localparam int VSW  = 2;
  localparam int VBP  = 1;
  localparam int HT   = HP + HFP + HSW + HBP;
  localparam int VT   = VP + VFP + VSW + VBP;
  localparam int FT   = HT * VT;
  localparam int NPIX = HP * VP;

  localparam logic [29:0] RESET_VEC = {24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        resetn;
  logic        tvalid;
  logic        tready;
  logic [1:0]  tdata;
  logic        tuser;
  logic [23:0] rgb;
  logic        hsync, vsync, de, locked, underflow, frame_err;
  logic [29:0] outs;

  assign outs = {rgb, de, hsync, vsync, locked, underflow, frame_err};

  svo_term_enc #(
    .SVO_HOR_PIXELS      (HP),
    .SVO_HOR_FRONT_PORCH (HFP),
    .SVO_HOR_SYNC        (HSW),
    .SVO_HOR_BACK_PORCH  (HBP),
    .SVO_VER_PIXELS      (VP),
    .SVO_VER_FRONT_PORCH (VFP),
    .SVO_VER_SYNC        (VSW),
    .SVO_VER_BACK_PORCH  (VBP),
    .SYNC_ACTIVE         (1'b0),
    .COLOR0              (24'h000000),
    .COLOR1              (24'h555555),
    .COLOR2              (24'hAAAAAA),
    .COLOR3              (24'hFFFFFF)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_axis_tvalid (tvalid),
    .in_axis_tready (tready),
    .in_axis_tdata  (tdata),
    .in_axis_tuser  (tuser),
    .rgb            (rgb),
    .hsync          (hsync),
    .vsync          (vsync),
    .de             (de),
    .locked         (locked),
    .underflow      (underflow),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Scenario record: stimulus knobs plus hand-derived expected totals.
  // kind: 0 none, 1 drop tvalid, 2 inject frame-start beat, 3 lose one source beat.
  typedef struct {
    int start_p;
    int kind;
    int fault_t;
    int frames;
    int exp_uf;
    int exp_fe;
    bit exp_locked;
  } scen_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: run-cycle count since raster start, lock flag, source.
  int         t;
  int         sync_left;
  bit         m_locked;
  int         p;
  logic [1:0] cur_data;
  int         uf_cnt, fe_cnt, de_cnt, hs_low, vs_low;
  logic [23:0] pal [4] = '{24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d sync_left=%0d)", name, act, exp, t, sync_left);
    end
  endtask

  // One clock: present the source beat, predict tready and the next registered outputs.
  task automatic tick(input bit drop, input bit jump, input bit skip);
    int x, y;
    bit act, org, rdy, uf_e, fe_e, hs_e, vs_e;
    logic [23:0] rgb_e;
    logic [29:0] exp;
    if (skip) begin p = (p + 1) % NPIX; cur_data = 2'($urandom); end
    if (jump) begin p = 0; cur_data = 2'($urandom); end
    tvalid = !drop;
    tuser  = (p == 0);
    tdata  = cur_data;
    #1;
    rdy = 0; uf_e = 0; fe_e = 0; rgb_e = 24'h0;
    if (sync_left > 0) begin
      exp = RESET_VEC;
    end else begin
      x    = t % HT;
      y    = (t / HT) % VT;
      act  = (x < HP) && (y < VP);
      org  = (x == 0) && (y == 0);
      hs_e = !((x >= HP + HFP) && (x < HP + HFP + HSW));
      vs_e = !((y >= VP + VFP) && (y < VP + VFP + VSW));
      if (!m_locked) begin
        rdy = tvalid && (!tuser || org);
        if (tvalid && tuser && org) begin
          m_locked = 1;
          rgb_e    = pal[tdata];
        end
      end else if (act) begin
        if (!tvalid) begin
          rdy = 1; uf_e = 1; m_locked = 0;
        end else if (tuser != org) begin
          fe_e = 1; m_locked = 0;
        end else begin
          rdy = 1; rgb_e = pal[tdata];
        end
      end
      exp = {rgb_e, act, hs_e, vs_e, m_locked, uf_e, fe_e};
    end
    check("tready", {31'b0, tready}, {31'b0, rdy});
    @(posedge clk);
    #1;
    check("outputs", {2'b0, outs}, {2'b0, exp});
    if (underflow === 1'b1) uf_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (de === 1'b1) de_cnt++;
    if (hsync === 1'b0) hs_low++;
    if (vsync === 1'b0) vs_low++;
    if (tvalid && rdy) begin p = (p + 1) % NPIX; cur_data = 2'($urandom); end
    if (sync_left > 0) sync_left--;
    else t++;
  endtask

  // Asynchronous reset: outputs must drop at once, before any clock edge.
  task automatic do_reset();
    resetn = 1'b0;
    tvalid = 1'b1;
    tuser  = 1'b0;
    tdata  = 2'd3;
    #1;
    check("async_reset_outputs", {2'b0, outs}, {2'b0, RESET_VEC});
    check("async_reset_tready", {31'b0, tready}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("held_reset_outputs", {2'b0, outs}, {2'b0, RESET_VEC});
    end
    resetn    = 1'b1;
    sync_left = 2;
    t         = 0;
    m_locked  = 0;
  endtask

  task automatic clear_counts();
    uf_cnt = 0; fe_cnt = 0; de_cnt = 0; hs_low = 0; vs_low = 0;
  endtask

  task automatic run_scen(input scen_t s, input int idx);
    bit f;
    do_reset();
    p        = s.start_p;
    cur_data = 2'($urandom);
    clear_counts();
    for (int i = 0; i < 2 + s.frames * FT; i++) begin
      f = (sync_left == 0) && (t == s.fault_t);
      tick(f && (s.kind == 1), f && (s.kind == 2), f && (s.kind == 3));
    end
    check($sformatf("scen%0d_underflows", idx), 32'(uf_cnt), 32'(s.exp_uf));
    check($sformatf("scen%0d_frame_errs", idx), 32'(fe_cnt), 32'(s.exp_fe));
    check($sformatf("scen%0d_locked_end", idx), {31'b0, locked}, {31'b0, s.exp_locked});
    check($sformatf("scen%0d_de_clocks", idx), 32'(de_cnt), 32'(NPIX * s.frames));
    check($sformatf("scen%0d_hsync_low", idx), 32'(hs_low), 32'(HSW * VT * s.frames));
    check($sformatf("scen%0d_vsync_low", idx), 32'(vs_low), 32'(VSW * HT * s.frames));
  endtask

  scen_t scen [9];
  int    first_de;

  initial begin
    // start_p, kind, fault_t, frames, exp_uf, exp_fe, exp_locked
    scen[0] = '{0,  0, -1,                3, 0, 0, 1'b1}; // clean stream from frame start
    scen[1] = '{10, 0, -1,                3, 0, 0, 1'b1}; // source joins mid-frame
    scen[2] = '{0,  1, 1 * HT + 3,        3, 1, 0, 1'b1}; // tvalid drop at (3,1)
    scen[3] = '{0,  2, 2 * HT + 4,        3, 0, 1, 1'b1}; // extra frame start at (4,2)
    scen[4] = '{0,  1, FT,                3, 1, 0, 1'b1}; // tvalid drop at origin
    scen[5] = '{0,  3, 1 * HT + 2,        3, 0, 1, 1'b1}; // lost beat: no tuser at origin
    scen[6] = '{0,  2, 3 * HT,            3, 0, 1, 1'b1}; // extra frame start at (0,3)
    scen[7] = '{0,  1, HP + HFP + 2,      3, 0, 0, 1'b1}; // drop in blanking is harmless
    scen[8] = '{0,  1, (VP - 1) * HT + HP - 1, 3, 1, 0, 1'b1}; // drop at last active pixel

    resetn    = 1'b1;
    tvalid    = 1'b0;
    tuser     = 1'b0;
    tdata     = 2'd0;
    t         = 0;
    sync_left = 2;
    m_locked  = 0;
    p         = 0;
    cur_data  = 2'd0;
    clear_counts();
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_scen(scen[i], i);
    end

    // Reset asserted mid-frame at (5,3) of the second frame, then restart at origin.
    do_reset();
    p = 0;
    cur_data = 2'($urandom);
    repeat (2 + FT + 3 * HT + 5) tick(1'b0, 1'b0, 1'b0);
    check("pre_reset_locked", {31'b0, locked}, 32'd1);
    do_reset();
    p = 0;
    cur_data = 2'($urandom);
    first_de = -1;
    for (int i = 0; i < 2 + FT; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (de === 1'b1 && first_de < 0) first_de = i;
    end
    check("first_de_after_release", 32'(first_de), 32'd2);
    check("relocked_after_reset", {31'b0, locked}, 32'd1);

    // Random source hiccups against the reference model.
    do_reset();
    p = 0;
    cur_data = 2'($urandom);
    for (int i = 0; i < 2400; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 249) == 0,
           $urandom_range(0, 249) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global bound so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/svo_term_enc.md
SVO_TERM_ENC -- requirements
Module: svo_term_enc

Interface
REQ-001 Param SVO_HOR_PIXELS, 640, active pixels per line.
REQ-002 Param SVO_VER_PIXELS, 480, active lines per frame.
REQ-003 Params SVO_HOR_FRONT_PORCH/SYNC/BACK_PORCH, 16/96/48, horizontal blanking segments in clocks.
REQ-004 Params SVO_VER_FRONT_PORCH/SYNC/BACK_PORCH, 10/2/33, vertical blanking segments in lines.
REQ-005 Param SYNC_ACTIVE, 0, level of hsync/vsync while asserted.
REQ-006 Params COLOR0..COLOR3, 24'h000000/24'h555555/24'hAAAAAA/24'hFFFFFF, palette for 2-bit pixel codes.
REQ-007 clk  in  1  single clock; all logic in this domain.
REQ-008 resetn  in  1  reset, asynchronous assert, active-low.
REQ-009 in_axis_tvalid  in  1  pixel beat valid.
REQ-010 in_axis_tready  out  1  pixel beat accepted when high with tvalid.
REQ-011 in_axis_tdata  in  2  pixel code.
REQ-012 in_axis_tuser  in  1  bit0: beat is first pixel of frame.
REQ-013 rgb  out  24  registered pixel colour, {R,G,B}.
REQ-014 hsync, vsync, de  out  1 each  registered timing, de high in active region.
REQ-015 locked  out  1  high while in RUN.
REQ-016 underflow, frame_err  out  1 each  single-cycle error pulses.

Function
REQ-017 hcnt wraps at H_TOTAL-1 (sum of horizontal params); vcnt increments on hcnt wrap, wraps at V_TOTAL-1; origin (0,0) = first active pixel.
REQ-018 Active region: hcnt<SVO_HOR_PIXELS and vcnt<SVO_VER_PIXELS; hsync asserted for hcnt in [HOR_PIXELS+HFP, HOR_PIXELS+HFP+HSYNC); vsync likewise on vcnt.
REQ-019 Counter width SHALL hold max(H_TOTAL,V_TOTAL)-1; no arithmetic overflow at wrap.
REQ-020 States: SYNC, RUN; reset enters SYNC.
REQ-021 SYNC: tready=1 when tvalid and !tuser (beat discarded); beat with tuser held (tready=0) until counters at (0,0), then consumed and state -> RUN.
REQ-022 RUN: tready = active region; beat consumed each active clock.
REQ-023 RUN, active, tvalid=0: emit COLOR0, pulse underflow, -> SYNC.
REQ-024 RUN, active, tvalid=1, tuser=1, position not (0,0): beat not consumed, COLOR0 emitted, pulse frame_err, -> SYNC.
REQ-025 RUN, position (0,0), tvalid=1, tuser=0: beat not consumed, COLOR0, pulse frame_err, -> SYNC.
REQ-026 Underflow and frame_err on the same clock: frame_err only.
REQ-027 Outputs registered: consumed pixel appears on rgb one clk after acceptance, aligned with de/hsync/vsync of that position.
REQ-028 rgb = COLOR0 whenever de=0 or no pixel consumed; palette index = tdata.
REQ-029 Timing counters run free in both states; state never stalls timing.
REQ-030 locked = (state==RUN), registered.

Reset
REQ-031 resetn low: hcnt=vcnt=0, state=SYNC, rgb=0, de=0, hsync=vsync=!SYNC_ACTIVE, locked=0, underflow=frame_err=0, tready=0.
REQ-032 Reset mid-frame: all above within asynchronous assertion; first active pixel after release is (0,0) one clk later.
REQ-033 Release SHALL be synchronized internally (2-flop) before counters start.

Structure
REQ-034 Timing param defaults and H_TOTAL/V_TOTAL derivation in the shared SVO defines/package, not local.
REQ-035 One sub-module natural: svo_term_timing (counters, hsync/vsync/de/active, at_origin flag).
REQ-036 State and palette logic in svo_term_enc top; total 120-400 lines.

Verification
REQ-037 Reset, then source streams 640x480 frames with tuser on first beat -> locked rises at first (0,0), every active pixel rgb matches palette of tdata, no error pulses over 3 frames.
REQ-038 Source starts mid-frame (no tuser on first 1000 beats) -> those beats discarded with tready=1, lock at next frame start.
REQ-039 Drop tvalid at (100,10) for one clk -> underflow pulse, rgb=0 at that pixel, locked=0, relock next frame.
REQ-040 Extra tuser beat at (320,240) -> frame_err pulse, beat not consumed, SYNC, relock on that held beat at next (0,0).
REQ-041 Check hsync low exactly 96 clks starting hcnt=656, vsync low 2 lines starting vcnt=490, de high 640x480 per frame.
REQ-042 Assert resetn low at (200,300) -> outputs reach reset values immediately; after release timing restarts at (0,0).
